// File: rtl/btb_update_ctrl.sv
// Branch-predictor update controller: two resolved-branch requesters feed a small
// FIFO of mispredict updates, which drains one predictor write per cycle.
module btb_update_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     stall_i,
  input  logic                     req0_valid_i,
  output logic                     req0_ready_o,
  input  logic                     req0_mispredict_i,
  input  logic                     req0_taken_i,
  input  logic [31:0]              req0_pc_i,
  input  logic [31:0]              req0_target_i,
  input  logic                     req1_valid_i,
  output logic                     req1_ready_o,
  input  logic                     req1_mispredict_i,
  input  logic                     req1_taken_i,
  input  logic [31:0]              req1_pc_i,
  input  logic [31:0]              req1_target_i,
  output logic                     upd_miss_o,
  output logic                     upd_taken_o,
  output logic [31:0]              upd_addr_o,
  output logic [31:0]              upd_target_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              upd_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
    logic [31:0] target;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            rr;

  logic [CW-1:0]   free;
  logic            conflict;
  logic            enq0;
  logic            enq1;
  logic            pop;
  logic [CW-1:0]   n_enq;
  entry_t          head;

  assign count_o = count;
  assign head    = mem[rd_ptr];

  // Ready arbitration from pre-pop occupancy; single free slot goes to rr on a tie.
  always_comb begin
    free         = CW'(DEPTH) - count;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    conflict     = 1'b0;
    if (rst_n && !flush_i) begin
      if (free >= CW'(2)) begin
        req0_ready_o = 1'b1;
        req1_ready_o = 1'b1;
      end else if (free == CW'(1)) begin
        if (req0_valid_i && req1_valid_i) begin
          conflict     = 1'b1;
          req0_ready_o = !rr;
          req1_ready_o = rr;
        end else begin
          req0_ready_o = req0_valid_i;
          req1_ready_o = req1_valid_i;
        end
      end
    end
  end

  always_comb begin
    enq0  = req0_valid_i && req0_ready_o && req0_mispredict_i;
    enq1  = req1_valid_i && req1_ready_o && req1_mispredict_i;
    pop   = (count != '0) && !stall_i && !flush_i;
    n_enq = CW'(enq0) + CW'(enq1);
  end

  // Storage is not reset; req0 lands ahead of req1 when both enqueue.
  always_ff @(posedge clk) begin
    if (enq0)
      mem[wr_ptr] <= '{taken: req0_taken_i, pc: req0_pc_i, target: req0_target_i};
    if (enq1)
      mem[enq0 ? wr_ptr + AW'(1) : wr_ptr] <=
        '{taken: req1_taken_i, pc: req1_pc_i, target: req1_target_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      rr           <= 1'b0;
      upd_miss_o   <= 1'b0;
      upd_taken_o  <= 1'b0;
      upd_addr_o   <= '0;
      upd_target_o <= '0;
      upd_cnt_o    <= '0;
    end else if (flush_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      upd_miss_o <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(n_enq);
      rd_ptr     <= rd_ptr + AW'(pop);
      count      <= count + n_enq - CW'(pop);
      upd_miss_o <= pop;
      if (conflict)
        rr <= !rr;
      if (pop) begin
        upd_taken_o  <= head.taken;
        upd_addr_o   <= head.pc;
        upd_target_o <= head.target;
        if (upd_cnt_o != 16'hFFFF)
          upd_cnt_o <= upd_cnt_o + 16'd1;
      end
    end
  end

endmodule
